// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the two-port memory access controller.
package mem_access_ctrl_pkg;

    // Width of a memory word and of every data path in the controller.
    localparam int DW = 8;

    // Access sequence: address/data setup, word select, latch hold.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Requester identity, used for both the current grant and the last grant.
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    // Round-robin pick. On a tie the port not granted last wins.
    // A single request wins outright. With no request the result is unused.
    function automatic port_t arbitrate(input logic a_req, input logic b_req, input port_t last);
        port_t pick;
        if (a_req && b_req) begin
            pick = (last == PORT_A) ? PORT_B : PORT_A;
        end else if (a_req) begin
            pick = PORT_A;
        end else begin
            pick = PORT_B;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_decoder.sv
// Address to one-hot word-select decoder. The enable forces all-zero.
module mem_decoder #(
    parameter int NWORDS = 8,
    parameter int AW     = $clog2(NWORDS)
) (
    input  logic [AW-1:0]     addr,
    input  logic              en,
    output logic [NWORDS-1:0] sel
);

    // Each select line compares the address against its own index.
    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_sel
            assign sel[gi] = en && (addr == AW'(gi));
        end
    endgenerate

endmodule

// File: rtl/mem_access_ctrl.sv
// Two-port round-robin access controller for a shared word array.
// Each access takes four cycles: IDLE (grant), SETUP, ACCESS (select), HOLD (ack).
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int NWORDS = 8,
    parameter int AW     = $clog2(NWORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [AW-1:0]     a_addr,
    input  logic [DW-1:0]     a_wdata,
    output logic              a_ack,
    output logic [DW-1:0]     a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [AW-1:0]     b_addr,
    input  logic [DW-1:0]     b_wdata,
    output logic              b_ack,
    output logic [DW-1:0]     b_rdata,
    output logic              mem_rw,
    output logic [NWORDS-1:0] mem_sel,
    output logic [DW-1:0]     mem_din,
    input  logic [DW-1:0]     mem_dout
);

    state_t          state_reg;
    state_t          state_next;
    port_t           grant_reg;
    port_t           last_reg;
    port_t           grant_pick;
    logic            we_reg;
    logic [AW-1:0]   addr_reg;
    logic [DW-1:0]   wdata_reg;
    logic [DW-1:0]   a_rdata_reg;
    logic [DW-1:0]   b_rdata_reg;
    logic            sel_en;
    logic            any_req;

    assign any_req    = a_req || b_req;
    assign grant_pick = arbitrate(a_req, b_req, last_reg);

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: only IDLE waits on a request; the rest walk the fixed sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = any_req ? SETUP : IDLE;
            SETUP:   state_next = ACCESS;
            ACCESS:  state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the granted request at grant time, and read data at the end of ACCESS.
    // we/wdata stay registered through HOLD, so mem_rw/mem_din cannot move while selected.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_reg   <= PORT_A;
            last_reg    <= PORT_B;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            a_rdata_reg <= '0;
            b_rdata_reg <= '0;
        end else begin
            if (state_reg == IDLE && any_req) begin
                grant_reg <= grant_pick;
                last_reg  <= grant_pick;
                we_reg    <= (grant_pick == PORT_A) ? a_we    : b_we;
                addr_reg  <= (grant_pick == PORT_A) ? a_addr  : b_addr;
                wdata_reg <= (grant_pick == PORT_A) ? a_wdata : b_wdata;
            end
            if (state_reg == ACCESS && !we_reg) begin
                if (grant_reg == PORT_A) begin
                    a_rdata_reg <= mem_dout;
                end else begin
                    b_rdata_reg <= mem_dout;
                end
            end
        end
    end

    // Outputs: select only in ACCESS, ack only in HOLD, control/data from the registers.
    always_comb begin
        sel_en  = (state_reg == ACCESS);
        a_ack   = (state_reg == HOLD) && (grant_reg == PORT_A);
        b_ack   = (state_reg == HOLD) && (grant_reg == PORT_B);
        mem_rw  = we_reg;
        mem_din = wdata_reg;
    end

    assign a_rdata = a_rdata_reg;
    assign b_rdata = b_rdata_reg;

    mem_decoder #(
        .NWORDS (NWORDS),
        .AW     (AW)
    ) u_decoder (
        .addr (addr_reg),
        .en   (sel_en),
        .sel  (mem_sel)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: table of single accesses plus
// hand-written arbitration and reset-abort sequences, with a behavioural word array.
module tb_mem_access_ctrl;

    logic       clk;
    logic       rst_n;
    logic       a_req, a_we, b_req, b_we;
    logic [2:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic       a_ack, b_ack;
    logic       mem_rw;
    logic [7:0] mem_sel;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_a_rd;
    logic [7:0] exp_b_rd;

    mem_access_ctrl #(.NWORDS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_ack    (a_ack),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_ack    (b_ack),
        .b_rdata  (b_rdata),
        .mem_rw   (mem_rw),
        .mem_sel  (mem_sel),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural word array: combinational read of the selected word, write on the edge.
    logic [7:0] model_mem [8];
    initial for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;

    always_comb begin
        mem_dout = 8'h00;
        for (int i = 0; i < 8; i++) if (mem_sel[i]) mem_dout = model_mem[i];
    end

    always @(posedge clk) begin
        if (mem_rw) for (int i = 0; i < 8; i++) if (mem_sel[i]) model_mem[i] <= mem_din;
    end

    // Per-cycle bus checker: one-hot-or-zero select, control/data stable around a select.
    logic [7:0] prev_sel = 8'h00;
    logic       prev_rw  = 1'b0;
    logic [7:0] prev_din = 8'h00;
    logic       prev_rst = 1'b0;
    int         sel_hits = 0;
    logic [7:0] last_sel = 8'h00;

    always @(negedge clk) begin
        tests++;
        if ($countones(mem_sel) > 1) begin
            fails++;
            $display("FAIL onehot: mem_sel=0x%02h is not one-hot-or-zero", mem_sel);
        end
        if (rst_n && prev_rst && (mem_sel != 8'h00 || prev_sel != 8'h00)) begin
            tests++;
            if (mem_rw !== prev_rw || mem_din !== prev_din) begin
                fails++;
                $display("FAIL stable: rw=%0b din=0x%02h changed from rw=%0b din=0x%02h around select",
                         mem_rw, mem_din, prev_rw, prev_din);
            end
        end
        if (mem_sel != 8'h00) begin
            sel_hits++;
            last_sel = mem_sel;
        end
        prev_sel = mem_sel;
        prev_rw  = mem_rw;
        prev_din = mem_din;
        prev_rst = rst_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        exp_a_rd = 8'h00;
        exp_b_rd = 8'h00;
    endtask

    // One access from a single port; checks latency, select pulse, ack width and rdata.
    task automatic run_single(input logic port, input logic we, input logic [2:0] addr,
                              input logic [7:0] wdata, input logic [7:0] exp_rd, input string name);
        int lat;
        int hits0;
        logic [7:0] exp_sel;
        @(negedge clk);
        hits0 = sel_hits;
        if (port == 1'b0) begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end else begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if ((port == 1'b0 && a_ack) || (port == 1'b1 && b_ack)) begin
                lat = c;
                break;
            end
        end
        check({name, " other_ack"}, (port == 1'b0) ? 32'(b_ack) : 32'(a_ack), 32'd0);
        a_req = 1'b0;
        b_req = 1'b0;
        #1;
        exp_sel = 8'd1 << addr;
        check({name, " latency"}, lat, 3);
        check({name, " sel_cycles"}, sel_hits - hits0, 1);
        check({name, " sel_value"}, 32'(last_sel), 32'(exp_sel));
        if (!we) begin
            if (port == 1'b0) exp_a_rd = exp_rd;
            else              exp_b_rd = exp_rd;
        end
        check({name, " a_rdata"}, 32'(a_rdata), 32'(exp_a_rd));
        check({name, " b_rdata"}, 32'(b_rdata), 32'(exp_b_rd));
        @(negedge clk);
        check({name, " ack_pulse"}, 32'({a_ack, b_ack}), 32'd0);
    endtask

    typedef struct {
        logic       port;
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        string      name;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_t, b_t, n, prev_c;
        int seen_ack;
        logic exp_port;

        vecs[0] = '{1'b0, 1'b1, 3'd3, 8'hA5, 8'h00, "A_wr3"};
        vecs[1] = '{1'b0, 1'b0, 3'd3, 8'h00, 8'hA5, "A_rd3"};
        vecs[2] = '{1'b1, 1'b1, 3'd7, 8'h3C, 8'h00, "B_wr7"};
        vecs[3] = '{1'b1, 1'b0, 3'd7, 8'h00, 8'h3C, "B_rd7"};
        vecs[4] = '{1'b0, 1'b1, 3'd0, 8'hFF, 8'h00, "A_wr0"};
        vecs[5] = '{1'b1, 1'b1, 3'd5, 8'h5A, 8'h00, "B_wr5"};
        vecs[6] = '{1'b0, 1'b0, 3'd5, 8'h00, 8'h5A, "A_rd5"};
        vecs[7] = '{1'b1, 1'b0, 3'd0, 8'h00, 8'hFF, "B_rd0"};

        rst_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = 3'd0; a_wdata = 8'h00;
        b_req = 1'b0; b_we = 1'b0; b_addr = 3'd0; b_wdata = 8'h00;
        exp_a_rd = 8'h00;
        exp_b_rd = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst mem_sel", 32'(mem_sel), 32'h0);
        check("rst mem_rw", 32'(mem_rw), 32'h0);
        check("rst mem_din", 32'(mem_din), 32'h0);
        check("rst acks", 32'({a_ack, b_ack}), 32'h0);
        check("rst a_rdata", 32'(a_rdata), 32'h0);
        check("rst b_rdata", 32'(b_rdata), 32'h0);
        #1;
        rst_n = 1'b1;

        // Table of single-port accesses
        for (int i = 0; i < 8; i++) begin
            run_single(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].name);
            $display("[TB] vector %0d %s done", i, vecs[i].name);
        end

        // Simultaneous requests from reset: A wins the tie, B follows 4 cycles later
        do_reset();
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd0; a_wdata = 8'h11;
        b_req = 1'b1; b_we = 1'b1; b_addr = 3'd1; b_wdata = 8'h22;
        a_t = 0;
        b_t = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (a_ack && a_t == 0) begin a_t = c; a_req = 1'b0; end
            if (b_ack && b_t == 0) begin b_t = c; b_req = 1'b0; end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check("tie a_ack_cycle", a_t, 3);
        check("tie b_ack_cycle", b_t, 7);
        $display("[TB] tie sequence: a_ack at %0d, b_ack at %0d", a_t, b_t);
        run_single(1'b0, 1'b0, 3'd0, 8'h00, 8'h11, "tie_A_rd0");
        run_single(1'b1, 1'b0, 3'd1, 8'h00, 8'h22, "tie_B_rd1");

        // Both ports requesting continuously: grants alternate A,B,A,B at one per 4 cycles
        do_reset();
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 3'd1;
        n = 0;
        prev_c = 0;
        for (int c = 1; c <= 60 && n < 8; c++) begin
            @(negedge clk);
            if (a_ack || b_ack) begin
                exp_port = n[0];
                check("rr single_ack", 32'({a_ack, b_ack}), exp_port ? 32'h1 : 32'h2);
                check("rr spacing", c - prev_c, (n == 0) ? 3 : 4);
                if (a_ack) check("rr a_rdata", 32'(a_rdata), 32'h11);
                if (b_ack) check("rr b_rdata", 32'(b_rdata), 32'h22);
                $display("[TB] rr grant %0d to %s at cycle %0d", n, a_ack ? "A" : "B", c);
                prev_c = c;
                n++;
                if (n == 8) begin a_req = 1'b0; b_req = 1'b0; end
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check("rr grant_count", n, 8);
        repeat (3) @(negedge clk);

        // Reset asserted during ACCESS of a write aborts it without ack
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd6; a_wdata = 8'h77;
        @(negedge clk);
        @(negedge clk);
        check("abort sel_in_access", 32'(mem_sel), 32'h40);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort mem_sel", 32'(mem_sel), 32'h0);
        check("abort mem_rw", 32'(mem_rw), 32'h0);
        check("abort mem_din", 32'(mem_din), 32'h0);
        check("abort rdata", 32'({a_rdata, b_rdata}), 32'h0);
        a_req = 1'b0;
        #1;
        rst_n = 1'b1;
        exp_a_rd = 8'h00;
        exp_b_rd = 8'h00;
        seen_ack = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (a_ack || b_ack) seen_ack++;
        end
        check("abort no_ack", seen_ack, 0);
        $display("[TB] reset-abort sequence done");

        // Controller is usable again after the abort; B read of addr 7 leaves a_rdata alone
        run_single(1'b1, 1'b0, 3'd7, 8'h00, 8'h3C, "post_B_rd7");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
